tohost_monitor: RTL and testbench

- Host-side responder for the riscv-tests HTIF "tohost" convention.
- Snoops the core's data-memory write port, captures writes to the TOHOST word, and decodes pass/fail plus the failing test number.
- Enforces a cycle timeout and presents a sticky, latched result to the bench.
- Benches use it to judge a test, rather than sampling a register file at a fixed tick count.

---
 rtl/tohost_pkg.sv | 26 ++
 rtl/tohost_monitor.sv | 95 +++++++++
 tb/tb_tohost_monitor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tohost_pkg.sv
// Shared definitions for the HTIF tohost monitor: state encoding, default
// tohost address, result codes and the byte-strobe merge helper.
package tohost_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [31:0] PASS_CODE       = 32'h0000_0001;
  localparam logic [31:0] RESULT_NONE     = 32'h0000_0000;

  // Replace each byte of old whose strobe is set with the matching data byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    merge_bytes = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) merge_bytes[8*i +: 8] = data[8*i +: 8];
  endfunction

endpackage

// File: rtl/tohost_monitor.sv
// Snoops data-memory writes for the tohost word, decodes pass/fail, enforces a
// RUN-cycle timeout and holds a sticky, registered result until reset.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
  parameter int          TIMEOUT     = 5000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_test,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [31:0]      tohost_q;
  logic [CNT_W-1:0] cycles_q;
  logic [30:0]      fail_test_q;
  logic             wr_ready_q, done_q, pass_q, fail_q, timeout_q;

  logic        hit, decide;
  logic [31:0] tohost_d;
  logic        unused_addr;

  // Byte lanes come from the strobes, so the low address bits carry no meaning.
  assign unused_addr = ^wr_addr[1:0];

  assign hit      = wr_valid && wr_ready_q && (state_q == S_RUN) &&
                    (wr_addr[31:2] == TOHOST_ADDR[31:2]);
  assign tohost_d = merge_bytes(tohost_q, wr_data, wr_strb);
  assign decide   = hit && (tohost_d != RESULT_NONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tohost_q    <= '0;
      cycles_q    <= '0;
      fail_test_q <= '0;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_RUN;
          wr_ready_q <= 1'b1;
        end
        S_RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
          if (hit) tohost_q <= tohost_d;
          // A deciding write beats a timeout landing on the same edge.
          if (decide) begin
            done_q <= 1'b1;
            if (tohost_d == PASS_CODE) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= S_FAIL;
              fail_q      <= 1'b1;
              fail_test_q <= tohost_d[0] ? tohost_d[31:1] : '0;
            end
          end else if (cycles_q == TO_LAST) begin
            state_q   <= S_TOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_ready  = wr_ready_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_test = fail_test_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed plus randomized bench for tohost_monitor, checked every cycle
// against an outcome-level reference model of the tohost protocol.
module tb_tohost_monitor;
  import tohost_pkg::*;

  localparam int          TOUT = 20;
  localparam logic [31:0] ADDR = TOHOST_ADDR_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        done, pass, fail, timeout;
  logic [30:0] fail_test;
  logic [31:0] cycles;

  tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT(TOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_test(fail_test), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Reference model: outcome of the test so far, in plain terms.
  localparam int R_NONE = 0, R_PASS = 1, R_FAIL = 2, R_TOUT = 3;
  bit          m_started;   // left the post-reset idle cycle
  int          m_res;
  longint      m_cyc;
  logic [31:0] m_val;
  logic [31:0] m_ft;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_started = 0; m_res = R_NONE; m_cyc = 0; m_val = '0; m_ft = '0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_res == R_NONE) begin
      if (m_cyc < 64'h0000_0000_FFFF_FFFF) m_cyc++;
      if (wr_valid && (wr_addr / 4 == ADDR / 4)) begin
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) m_val[8*i +: 8] = wr_data[8*i +: 8];
        if (m_val == 1) m_res = R_PASS;
        else if (m_val != 0) begin
          m_res = R_FAIL;
          m_ft  = (m_val % 2 == 1) ? m_val / 2 : 32'd0;
        end
      end
      // The TIMEOUT-th RUN edge without a result is a timeout.
      if (m_res == R_NONE && m_cyc == TOUT) m_res = R_TOUT;
    end
  endtask

  task automatic check_all();
    chk("wr_ready",  {31'd0, wr_ready}, {31'd0, m_started});
    chk("done",      {31'd0, done},     {31'd0, m_res != R_NONE});
    chk("pass",      {31'd0, pass},     {31'd0, m_res == R_PASS});
    chk("fail",      {31'd0, fail},     {31'd0, m_res == R_FAIL});
    chk("timeout",   {31'd0, timeout},  {31'd0, m_res == R_TOUT});
    chk("fail_test", {1'b0, fail_test}, m_ft);
    chk("cycles",    cycles,            m_cyc[31:0]);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    rst = r; wr_valid = v; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b1, 1'b1, a, d, s);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle();                         // IDLE -> RUN edge
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    m_started = 0; m_res = R_NONE; m_cyc = 0; m_val = '0; m_ft = '0;

    // Reset state, then release and idle.
    step(1'b0, 1'b1, ADDR, 32'h1, 4'hF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    idle(); idle(); idle();
    chk("idle_cycles", cycles, 32'd2);

    // Full-word pass, then a late failing write is ignored.
    wr(ADDR, 32'h1, 4'hF);
    chk("pass_set", {31'd0, pass}, 32'd1);
    idle(); idle();
    wr(ADDR, 32'h7, 4'hF);
    chk("pass_sticky", {31'd0, pass}, 32'd1);
    chk("pass_frozen", cycles, 32'd3);

    // Reset from PASS; odd failure code.
    do_reset();
    chk("rst_from_pass", {31'd0, done}, 32'd0);
    wr(ADDR, 32'h0000_0007, 4'hF);
    chk("fail_code3", {1'b0, fail_test}, 32'd3);

    // Byte writes: the first byte alone already decides.
    do_reset();
    wr(ADDR, 32'h0000_000B, 4'b0001);
    wr(ADDR, 32'h0000_0100, 4'b0010);
    chk("byte_first", {1'b0, fail_test}, 32'd5);

    // Zero-leaving partial write, empty strobe, then a two-byte write = 0x10B.
    do_reset();
    wr(ADDR, 32'hFFFF_FFFF, 4'b0000);
    wr(ADDR + 32'd2, 32'h0000_0000, 4'b0100);
    wr(ADDR, 32'hDEAD_010B, 4'b0011);
    chk("byte_10b", {1'b0, fail_test}, 32'h85);

    // Neighbour word is ignored; even value is a protocol error.
    do_reset();
    wr(ADDR + 32'd4, 32'h1, 4'hF);
    chk("neighbour", {31'd0, done}, 32'd0);
    wr(ADDR, 32'h2, 4'hF);
    chk("even_fail", {31'd0, fail}, 32'd1);

    // Pure timeout.
    do_reset();
    repeat (TOUT) idle();
    chk("tout_flag", {31'd0, timeout}, 32'd1);
    chk("tout_cycles", cycles, 32'd20);
    idle(); idle();

    // Deciding write on the timeout edge wins.
    do_reset();
    repeat (TOUT - 1) idle();
    wr(ADDR, 32'h1, 4'hF);
    chk("race_pass", {31'd0, pass}, 32'd1);
    chk("race_tout", {31'd0, timeout}, 32'd0);

    // Reset mid-RUN, then decide afresh.
    do_reset();
    idle(); idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("midrun_rst", cycles, 32'd0);
    idle();
    wr(ADDR, 32'h0000_0009, 4'hF);
    idle();

    // Randomized episodes.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        case ($urandom_range(0, 3))
          0: a = ADDR;
          1: a = ADDR + 32'($urandom_range(1, 3));
          2: a = ADDR + 32'd4;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: d = 32'h0;
          1: d = 32'h1;
          2: d = 32'($urandom_range(0, 15)) * 2 + 32'd1;
          default: d = $urandom;
        endcase
        s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0), a, d, s);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
